// File: rtl/rr_output_alloc.sv
// Wormhole output allocator: round-robin picks an input owner, holds it until
// the tail flit transfers, and gates transfers on downstream credits.
module rr_output_alloc #(
    parameter int unsigned CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [4:0] tail,
    input  logic       credit_in,
    output logic [4:0] gnt,
    output logic       fwd_valid,
    output logic [3:0] credit_cnt,
    output logic       cr_err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;
    logic [4:0] gnt_q, gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic       found;
    logic [2:0] pick;
    logic [3:0] idx;

    // Rotating priority search starting at ptr, modulo 5.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'd5) begin
                idx = idx - 4'd5;
            end
            if (!found && req[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fwd_valid = (state_q == LOCKED) && req[owner_q] && (cnt_q != '0);

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    owner_d = pick;
                    gnt_d   = 5'(5'b00001 << pick);
                end
            end
            LOCKED: begin
                if (fwd_valid && tail[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A freed slot arriving while already full is dropped and flagged.
        if (fwd_valid && !credit_in) begin
            cnt_d = cnt_q - 4'd1;
        end else if (!fwd_valid && credit_in) begin
            if (cnt_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= CRED_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign gnt        = gnt_q;
    assign credit_cnt = cnt_q;
    assign cr_err     = err_q;

endmodule

// File: tb/tb_rr_output_alloc.sv
// Scoreboard bench for rr_output_alloc: each stimulus cycle queues the expected
// outputs; a monitor pops and compares at the falling edge or on async events.
module tb_rr_output_alloc;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] gnt;
    logic       fwd_valid;
    logic [3:0] credit_cnt;
    logic       cr_err;

    typedef struct {
        string      name;
        int         idx;
        logic [4:0] gnt;
        logic       fv;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    step_no = 0;
    string cur_test = "reset";
    logic  async_tick = 1'b0;

    rr_output_alloc #(.CREDITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .gnt        (gnt),
        .fwd_valid  (fwd_valid),
        .credit_cnt (credit_cnt),
        .cr_err     (cr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [4:0] eg, input logic ef,
                            input logic [3:0] ec, input logic ee);
        exp_t e;
        e.name = cur_test;
        e.idx  = step_no;
        e.gnt  = eg;
        e.fv   = ef;
        e.cnt  = ec;
        e.err  = ee;
        exp_q.push_back(e);
        step_no++;
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic [4:0] r, input logic [4:0] t, input logic c,
                        input logic [4:0] eg, input logic ef,
                        input logic [3:0] ec, input logic ee);
        req       = r;
        tail      = t;
        credit_in = c;
        push_exp(eg, ef, ec, ee);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst       = 1'b1;
        req       = '0;
        tail      = '0;
        credit_in = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cur_test = nm;
        step_no  = 0;
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or async_tick);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.gnt || fwd_valid !== e.fv ||
                    credit_cnt !== e.cnt || cr_err !== e.err) begin
                    errors++;
                    $display("FAIL %s[%0d]: got gnt=%b fwd_valid=%b credit_cnt=%0d cr_err=%b, expected gnt=%b fwd_valid=%b credit_cnt=%0d cr_err=%b",
                             e.name, e.idx, gnt, fwd_valid, credit_cnt, cr_err,
                             e.gnt, e.fv, e.cnt, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst       = 1'b1;
        req       = '0;
        tail      = '0;
        credit_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);

        cur_test = "round_robin";
        step_no  = 0;
        step(5'b11111, 5'b11111, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b11111, 5'b11111, 0, 5'b00001, 1, 4'd4, 0);
        step(5'b11111, 5'b11111, 1, 5'b00000, 0, 4'd3, 0);
        step(5'b11111, 5'b11111, 0, 5'b00010, 1, 4'd4, 0);
        step(5'b11111, 5'b11111, 1, 5'b00000, 0, 4'd3, 0);
        step(5'b11111, 5'b11111, 0, 5'b00100, 1, 4'd4, 0);
        step(5'b11111, 5'b11111, 1, 5'b00000, 0, 4'd3, 0);
        step(5'b11111, 5'b11111, 0, 5'b01000, 1, 4'd4, 0);
        step(5'b11111, 5'b11111, 1, 5'b00000, 0, 4'd3, 0);
        step(5'b11111, 5'b11111, 0, 5'b10000, 1, 4'd4, 0);
        step(5'b11111, 5'b11111, 1, 5'b00000, 0, 4'd3, 0);
        step(5'b11111, 5'b11111, 0, 5'b00001, 1, 4'd4, 0);
        step(5'b00000, 5'b00000, 1, 5'b00000, 0, 4'd3, 0);

        do_reset("lock");
        step(5'b00100, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b00101, 5'b00001, 0, 5'b00100, 1, 4'd4, 0);
        step(5'b00001, 5'b00001, 0, 5'b00100, 0, 4'd3, 0);
        step(5'b00101, 5'b00001, 0, 5'b00100, 1, 4'd3, 0);
        step(5'b00101, 5'b00100, 0, 5'b00100, 1, 4'd2, 0);
        step(5'b00001, 5'b00000, 1, 5'b00000, 0, 4'd1, 0);
        step(5'b00001, 5'b00001, 0, 5'b00001, 1, 4'd2, 0);
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd1, 0);

        do_reset("credit_stall");
        step(5'b01000, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 1, 4'd4, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 1, 4'd3, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 1, 4'd2, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 1, 4'd1, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 0, 4'd0, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 0, 4'd0, 0);
        step(5'b01000, 5'b00000, 1, 5'b01000, 0, 4'd0, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 1, 4'd1, 0);
        step(5'b01000, 5'b01000, 0, 5'b01000, 0, 4'd0, 0);
        step(5'b01000, 5'b01000, 1, 5'b01000, 0, 4'd0, 0);
        step(5'b01000, 5'b01000, 0, 5'b01000, 1, 4'd1, 0);
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd0, 0);

        do_reset("simultaneous");
        step(5'b00010, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b00010, 5'b00000, 0, 5'b00010, 1, 4'd4, 0);
        step(5'b00010, 5'b00000, 0, 5'b00010, 1, 4'd3, 0);
        step(5'b00010, 5'b00000, 1, 5'b00010, 1, 4'd2, 0);
        step(5'b00010, 5'b00010, 0, 5'b00010, 1, 4'd2, 0);
        step(5'b00000, 5'b00000, 1, 5'b00000, 0, 4'd1, 0);
        step(5'b00000, 5'b00000, 1, 5'b00000, 0, 4'd2, 0);
        step(5'b00000, 5'b00000, 1, 5'b00000, 0, 4'd3, 0);
        step(5'b00000, 5'b00000, 1, 5'b00000, 0, 4'd4, 0);
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd4, 1);
        step(5'b00100, 5'b00000, 0, 5'b00000, 0, 4'd4, 1);
        step(5'b00100, 5'b00100, 1, 5'b00100, 1, 4'd4, 1);
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd4, 1);

        do_reset("wrap");
        step(5'b10000, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b10001, 5'b10000, 0, 5'b10000, 1, 4'd4, 0);
        step(5'b10001, 5'b00000, 0, 5'b00000, 0, 4'd3, 0);
        step(5'b10001, 5'b00001, 0, 5'b00001, 1, 4'd3, 0);
        step(5'b10001, 5'b00000, 0, 5'b00000, 0, 4'd2, 0);
        step(5'b10000, 5'b10000, 0, 5'b10000, 1, 4'd2, 0);
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd1, 0);

        cur_test = "async_reset";
        step_no  = 0;
        step(5'b01000, 5'b00000, 0, 5'b00000, 0, 4'd1, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 1, 4'd1, 0);
        step(5'b01000, 5'b00000, 0, 5'b01000, 0, 4'd0, 0);
        // Mid-cycle reset while LOCKED on input 3 with req still asserted.
        rst = 1'b1;
        #1;
        push_exp(5'b00000, 0, 4'd4, 0);
        async_tick = ~async_tick;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b01000, 5'b00000, 0, 5'b00000, 0, 4'd4, 0);
        step(5'b01000, 5'b01000, 0, 5'b01000, 1, 4'd4, 0);
        step(5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd3, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_output_alloc.md
RR_OUTPUT_ALLOC -- requirements
Module: rr_output_alloc

Interface
REQ-001 The block SHALL have parameter CREDITS, default 4, giving the number of downstream buffer slots (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 5 bits: bit i high means input port i has a flit for this output.
REQ-005 The block SHALL have port tail, input, 5 bits: bit i high means the flit at input i is the last flit of its packet; tail[i] is qualified by req[i].
REQ-006 The block SHALL have port credit_in, input, 1 bit: a one-cycle pulse meaning one downstream slot was freed.
REQ-007 The block SHALL have port gnt, output, 5 bits: registered, one-hot or zero; names the input that owns the output.
REQ-008 The block SHALL have port fwd_valid, output, 1 bit: combinational; high means a flit transfers this cycle.
REQ-009 The block SHALL have port credit_cnt, output, 4 bits: registered count of available downstream slots.
REQ-010 The block SHALL have port cr_err, output, 1 bit: sticky flag for credit overflow.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and LOCKED (owner held until tail).
REQ-012 In IDLE, when req != 0 at a rising edge, the block SHALL pick the first set req bit searching ptr, ptr+1, ... modulo 5, store it as owner, set gnt to the owner's one-hot value and enter LOCKED; gnt is first visible one cycle after the request.
REQ-013 In IDLE, arbitration SHALL NOT depend on credit_cnt.
REQ-014 In IDLE, gnt SHALL be 0 and fwd_valid SHALL be 0.
REQ-015 In LOCKED, fwd_valid SHALL equal req[owner] AND (credit_cnt != 0).
REQ-016 In LOCKED, requests from non-owners SHALL be ignored.
REQ-017 If the owner deasserts req while LOCKED, the block SHALL stay LOCKED with gnt unchanged (wormhole bubble).
REQ-018 A cycle with fwd_valid=1 and tail[owner]=1 SHALL move the FSM to IDLE, clear gnt and set ptr = (owner+1) mod 5, all at the next edge.
REQ-019 No new grant SHALL be issued in the cycle the tail transfers; the earliest next gnt is two cycles after the tail flit.
REQ-020 Each edge SHALL update credit_cnt by -1 for fwd_valid, +1 for credit_in, and leave it unchanged when both occur.
REQ-021 credit_in while credit_cnt == CREDITS and fwd_valid == 0 SHALL leave credit_cnt at CREDITS and set cr_err=1 until reset.
REQ-022 credit_cnt SHALL never go below 0; this follows from fwd_valid requiring credit_cnt != 0.
REQ-023 ptr SHALL be a 3-bit register holding only the values 0..4; wrap from 4 to 0 SHALL be explicit.

Reset
REQ-024 rst high SHALL immediately force: FSM=IDLE, gnt=0, ptr=0, credit_cnt=CREDITS, cr_err=0, and fwd_valid=0 via state.
REQ-025 Reset asserted mid-packet SHALL discard ownership with no partial-packet recovery.
REQ-026 After rst deassertion, the first arbitration SHALL occur at the first rising edge with req != 0.

Verification
REQ-027 Round-robin: req=5'b11111 held with tail=5'b11111, ample credits -> gnt sequence 00001, 0, 00010, 0, 00100, 0, 01000, 0, 10000, 0, 00001.
REQ-028 Lock: input 2 granted and sending a 3-flit packet (tail on the 3rd) while req[0]=1 -> gnt stays 00100 for 3 transfers, then 0, then 00001.
REQ-029 Credit stall: CREDITS=4, no credit_in, a 6-flit packet -> exactly 4 fwd_valid pulses, credit_cnt reaches 0, fwd_valid stays 0 until a credit_in pulse, then 1 more transfer.
REQ-030 Simultaneous: fwd_valid=1 and credit_in=1 in the same cycle with credit_cnt=2 -> credit_cnt=2 next cycle; credit_in at credit_cnt=4, idle -> credit_cnt=4, cr_err=1.
REQ-031 Wrap: owner=4 finishes its tail with req=5'b10001 -> the next grant is 00001 (ptr=0).
REQ-032 Async reset: rst pulsed between edges while LOCKED on input 3 -> gnt=0 and credit_cnt=4 immediately, without waiting for a clock edge.
